// File: rtl/lke_pkg.sv
// Shared definitions for the lookup-engine CAM stage: control header field
// offsets, the control FSM encoding and the payload byte-swap helper.
package lke_pkg;

    localparam int DATA_W     = 512;
    localparam int MOD_ID_OFF = 368;
    localparam int RESV_OFF   = 376;
    localparam int FLAG_OFF   = 320;
    localparam int IDX_OFF    = 384;

    localparam logic [15:0] CTRL_FLAG = 16'hf2f1;

    typedef enum logic [0:0] {
        IDLE_C  = 1'b0,
        WRITE_C = 1'b1
    } ctrl_state_t;

    // Control payloads arrive little-endian; entries are stored big-endian.
    function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            s[i*8 +: 8] = d[DATA_W-8-i*8 +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/lke_cam_prio_enc.sv
// Priority encoder for the CAM hit vector: lowest set bit wins, index 0 when
// nothing hits.
module lke_cam_prio_enc (
    input  logic [15:0] hit,
    output logic [3:0]  idx,
    output logic        any
);

    always_comb begin
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (hit[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign any = |hit;

endmodule

// File: rtl/lke_cam_part.sv
// Match stage: 16-entry masked register CAM in front of the action RAM.
// Entries are loaded in-band over the AXI-Stream control path.
module lke_cam_part
    import lke_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int LOOKUP_ID            = 2,
    parameter int PHV_LEN              = 48*8 + 32*8 + 16*8 + 256,
    parameter int KEY_LEN              = 48*2 + 32*2 + 16*2 + 5,
    parameter int CAM_DEPTH            = 16
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [PHV_LEN-1:0]                phv_in,
    input  logic [KEY_LEN-1:0]                key_in,
    input  logic [KEY_LEN-1:0]                key_mask_in,
    input  logic                              key_valid,
    output logic                              ready_out,

    output logic [PHV_LEN-1:0]                phv_out,
    output logic                              phv_valid,
    output logic [3:0]                        match_addr,
    output logic                              if_match,
    input  logic                              ready_in,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);

    logic [KEY_LEN-1:0]   cam [CAM_DEPTH];
    logic [CAM_DEPTH-1:0] entry_valid;
    logic [CAM_DEPTH-1:0] hit;
    logic [3:0]           hit_idx;
    logic                 hit_any;
    logic                 accept;

    ctrl_state_t          state;
    logic [3:0]           idx;
    logic [7:0]           mod_id;
    logic                 for_me;
    logic [KEY_LEN-1:0]   wr_key;

    assign ready_out = ~phv_valid | ready_in;
    assign accept    = key_valid & ready_out;

    // Hits read the registered CAM, so a same-cycle write is seen one cycle later.
    always_comb begin
        hit = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            hit[i] = entry_valid[i] && (((key_in ^ cam[i]) & ~key_mask_in) == '0);
        end
    end

    lke_cam_prio_enc u_prio_enc (
        .hit (hit),
        .idx (hit_idx),
        .any (hit_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phv_out    <= '0;
            phv_valid  <= 1'b0;
            match_addr <= 4'd0;
            if_match   <= 1'b0;
        end else if (accept) begin
            phv_out    <= phv_in;
            phv_valid  <= 1'b1;
            match_addr <= hit_idx;
            if_match   <= hit_any;
        end else if (ready_in) begin
            phv_valid  <= 1'b0;
        end
    end

    assign mod_id = c_s_axis_tdata[MOD_ID_OFF +: 8];
    assign for_me = (mod_id[7:3] == 5'(STAGE_ID)) &&
                    (mod_id[2:0] == 3'(LOOKUP_ID)) &&
                    (c_s_axis_tdata[FLAG_OFF +: 16] == CTRL_FLAG) &&
                    (c_s_axis_tdata[RESV_OFF +: 4] == 4'd0);

    // The entry key is the top KEY_LEN bits of the byte-swapped beat.
    assign wr_key = KEY_LEN'(byte_swap(c_s_axis_tdata) >> (DATA_W - KEY_LEN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE_C;
            idx             <= 4'd0;
            entry_valid     <= '0;
            for (int i = 0; i < CAM_DEPTH; i++) begin
                cam[i] <= '0;
            end
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
        end else begin
            c_m_axis_tdata  <= '0;
            c_m_axis_tuser  <= '0;
            c_m_axis_tkeep  <= '0;
            c_m_axis_tvalid <= 1'b0;
            c_m_axis_tlast  <= 1'b0;
            case (state)
                IDLE_C: begin
                    if (c_s_axis_tvalid) begin
                        if (for_me) begin
                            idx <= c_s_axis_tdata[IDX_OFF +: 4];
                            if (!c_s_axis_tlast) begin
                                state <= WRITE_C;
                            end
                        end else begin
                            c_m_axis_tdata  <= c_s_axis_tdata;
                            c_m_axis_tuser  <= c_s_axis_tuser;
                            c_m_axis_tkeep  <= c_s_axis_tkeep;
                            c_m_axis_tvalid <= 1'b1;
                            c_m_axis_tlast  <= c_s_axis_tlast;
                        end
                    end
                end
                WRITE_C: begin
                    if (c_s_axis_tvalid) begin
                        cam[idx]         <= wr_key;
                        entry_valid[idx] <= 1'b1;
                        idx              <= idx + 4'd1;
                        if (c_s_axis_tlast) begin
                            state <= IDLE_C;
                        end
                    end
                end
                default: state <= IDLE_C;
            endcase
        end
    end

endmodule

// File: tb/tb_lke_cam_part.sv
// Randomized bench for lke_cam_part against a behavioural lookup/control model.
module tb_lke_cam_part;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int PL = 1024;
    localparam int KL = 197;

    logic            clk = 1'b0;
    logic            rst;
    logic [PL-1:0]   phv_in;
    logic [KL-1:0]   key_in;
    logic [KL-1:0]   key_mask_in;
    logic            key_valid;
    logic            ready_out;
    logic [PL-1:0]   phv_out;
    logic            phv_valid;
    logic [3:0]      match_addr;
    logic            if_match;
    logic            ready_in;
    logic [DW-1:0]   c_s_axis_tdata;
    logic [UW-1:0]   c_s_axis_tuser;
    logic [DW/8-1:0] c_s_axis_tkeep;
    logic            c_s_axis_tvalid;
    logic            c_s_axis_tlast;
    logic [DW-1:0]   c_m_axis_tdata;
    logic [UW-1:0]   c_m_axis_tuser;
    logic [DW/8-1:0] c_m_axis_tkeep;
    logic            c_m_axis_tvalid;
    logic            c_m_axis_tlast;

    lke_cam_part dut (
        .clk(clk), .rst(rst),
        .phv_in(phv_in), .key_in(key_in), .key_mask_in(key_mask_in),
        .key_valid(key_valid), .ready_out(ready_out),
        .phv_out(phv_out), .phv_valid(phv_valid), .match_addr(match_addr),
        .if_match(if_match), .ready_in(ready_in),
        .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser),
        .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tvalid(c_s_axis_tvalid),
        .c_s_axis_tlast(c_s_axis_tlast),
        .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
        .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid),
        .c_m_axis_tlast(c_m_axis_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]   data;
        logic [UW-1:0]   user;
        logic [DW/8-1:0] keep;
        logic            last;
    } beat_t;

    beat_t ctrl_q[$];

    int n_vectors;
    int n_miscompares;

    // Reference state: CAM image, control packet tracking, expected outputs.
    logic [KL-1:0] cam_m [16];
    bit            valid_m [16];
    bit            m_in_pkt;
    int            m_idx;
    bit            exp_valid;
    logic [PL-1:0] exp_phv;
    logic [3:0]    exp_addr;
    bit            exp_match;
    logic [705:0]  exp_ctrl;

    task automatic check_output(input string tag, input logic [719:0] obs, input logic [719:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PL-1:0] rand_wide();
        logic [PL-1:0] r;
        for (int i = 0; i < PL / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [KL-1:0] rand_key();
        logic [PL-1:0] r;
        r = rand_wide();
        return r[KL-1:0];
    endfunction

    function automatic logic [DW-1:0] rev_bytes(input logic [DW-1:0] d);
        logic [DW-1:0] s;
        for (int b = 0; b < DW / 8; b++) s[(DW/8-1-b)*8 +: 8] = d[b*8 +: 8];
        return s;
    endfunction

    function automatic bit model_for_me(input logic [DW-1:0] d);
        return d[371 +: 5] == 5'd0 && d[368 +: 3] == 3'd2 &&
               d[335:320] == 16'hf2f1 && d[376 +: 4] == 4'd0;
    endfunction

    function automatic int model_lookup(input logic [KL-1:0] k, input logic [KL-1:0] m);
        for (int i = 0; i < 16; i++) begin
            if (valid_m[i] && ((k ^ cam_m[i]) & ~m) == '0) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            cam_m[i] = '0;
            valid_m[i] = 1'b0;
        end
        m_in_pkt = 0; m_idx = 0;
        exp_valid = 0; exp_phv = '0; exp_addr = 4'd0; exp_match = 0; exp_ctrl = '0;
    endtask

    task automatic push_packet(input logic [7:0] mod_id, input logic [3:0] resv, input logic [15:0] flag,
                               input logic [7:0] idx, input int n, input logic [KL-1:0] k0,
                               input logic [KL-1:0] k1, input logic [KL-1:0] k2);
        beat_t b;
        logic [KL-1:0] ks [3];
        logic [PL-1:0] r;
        ks[0] = k0; ks[1] = k1; ks[2] = k2;
        r = rand_wide();
        b.data = r[DW-1:0];
        b.data[368 +: 8] = mod_id;
        b.data[376 +: 4] = resv;
        b.data[335:320] = flag;
        b.data[384 +: 8] = idx;
        b.user = r[DW +: UW];
        b.keep = r[PL-1 -: 64];
        b.last = (n == 0);
        ctrl_q.push_back(b);
        for (int i = 0; i < n; i++) begin
            r = rand_wide();
            b.data = rev_bytes({ks[i], r[DW-KL-1:0]});
            b.user = r[DW +: UW];
            b.keep = r[PL-1 -: 64];
            b.last = (i == n - 1);
            ctrl_q.push_back(b);
        end
    endtask

    task automatic drive_ctrl(input bit allow_gap);
        logic [PL-1:0] r;
        if (ctrl_q.size() != 0 && !(allow_gap && $urandom_range(0, 3) == 0)) begin
            beat_t b;
            b = ctrl_q.pop_front();
            c_s_axis_tvalid = 1'b1;
            c_s_axis_tdata  = b.data;
            c_s_axis_tuser  = b.user;
            c_s_axis_tkeep  = b.keep;
            c_s_axis_tlast  = b.last;
        end else begin
            r = rand_wide();
            c_s_axis_tvalid = 1'b0;
            c_s_axis_tdata  = r[DW-1:0];
            c_s_axis_tuser  = r[DW +: UW];
            c_s_axis_tkeep  = r[PL-1 -: 64];
            c_s_axis_tlast  = r[PL-1];
        end
    endtask

    // Inputs are already driven (at a falling edge); model one clock and compare.
    task automatic apply_stimulus();
        int h;
        #1;
        check_output("ready_out", ready_out, !exp_valid || ready_in);
        if (key_valid && (!exp_valid || ready_in)) begin
            h = model_lookup(key_in, key_mask_in);
            exp_valid = 1;
            exp_phv   = phv_in;
            exp_match = (h >= 0);
            exp_addr  = (h >= 0) ? 4'(h) : 4'd0;
        end else if (ready_in) begin
            exp_valid = 0;
        end
        exp_ctrl = '0;
        if (c_s_axis_tvalid) begin
            if (!m_in_pkt) begin
                if (model_for_me(c_s_axis_tdata)) begin
                    m_idx    = int'(c_s_axis_tdata[384 +: 4]);
                    m_in_pkt = !c_s_axis_tlast;
                end else begin
                    exp_ctrl = {1'b1, c_s_axis_tlast, c_s_axis_tkeep, c_s_axis_tuser, c_s_axis_tdata};
                end
            end else begin
                cam_m[m_idx]   = KL'(rev_bytes(c_s_axis_tdata) >> (DW - KL));
                valid_m[m_idx] = 1'b1;
                m_idx          = (m_idx + 1) % 16;
                if (c_s_axis_tlast) m_in_pkt = 0;
            end
        end
        @(negedge clk);
        check_output("phv_valid", phv_valid, exp_valid);
        check_output("if_match", if_match, exp_match);
        check_output("match_addr", match_addr, exp_addr);
        check_output("phv_hi", phv_out[PL-1:DW], exp_phv[PL-1:DW]);
        check_output("phv_lo", phv_out[DW-1:0], exp_phv[DW-1:0]);
        check_output("ctrl_out", {c_m_axis_tvalid, c_m_axis_tlast, c_m_axis_tkeep, c_m_axis_tuser, c_m_axis_tdata}, exp_ctrl);
    endtask

    task automatic flush_ctrl();
        key_valid = 1'b0;
        ready_in  = 1'b1;
        while (ctrl_q.size() != 0) begin
            drive_ctrl(1'b0);
            apply_stimulus();
        end
        drive_ctrl(1'b0);
        apply_stimulus();
    endtask

    task automatic do_lookup(input string tag, input logic [KL-1:0] k, input logic [KL-1:0] m,
                             input logic [3:0] want_addr, input bit want_match);
        logic [PL-1:0] p;
        p = rand_wide();
        drive_ctrl(1'b0);
        key_valid = 1'b1; key_in = k; key_mask_in = m; phv_in = p; ready_in = 1'b1;
        apply_stimulus();
        check_output({tag, "_match"}, if_match, want_match);
        check_output({tag, "_addr"}, match_addr, want_addr);
        check_output({tag, "_phv"}, phv_out[DW-1:0], p[DW-1:0]);
        key_valid = 1'b0;
    endtask

    logic [KL-1:0] k5, k3, k9, ka, kb, kr, mr;

    initial begin
        n_vectors = 0;
        n_miscompares = 0;
        rst = 1'b1;
        key_valid = 1'b0; key_in = '0; key_mask_in = '0; phv_in = '0; ready_in = 1'b1;
        drive_ctrl(1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        check_output("rst_ready_out", ready_out, 1'b1);
        check_output("rst_phv_valid", phv_valid, 1'b0);
        check_output("rst_c_m_tvalid", c_m_axis_tvalid, 1'b0);
        rst = 1'b0;

        do_lookup("rst_lookup", '0, '0, 4'd0, 1'b0);

        k5 = rand_key();
        push_packet(8'h02, 4'd0, 16'hf2f1, 8'd5, 1, k5, '0, '0);
        flush_ctrl();
        do_lookup("hit5", k5, '0, 4'd5, 1'b1);

        k3 = rand_key();
        k9 = k3 ^ KL'(1);
        push_packet(8'h02, 4'd0, 16'hf2f1, 8'd3, 1, k3, '0, '0);
        push_packet(8'h02, 4'd0, 16'hf2f1, 8'd9, 1, k9, '0, '0);
        flush_ctrl();
        do_lookup("prio", k9, KL'(1), 4'd3, 1'b1);
        do_lookup("exact9", k9, '0, 4'd9, 1'b1);

        ka = rand_key();
        kb = rand_key();
        push_packet(8'h02, 4'd0, 16'hf2f1, 8'd15, 2, ka, kb, '0);
        flush_ctrl();
        do_lookup("wrap15", ka, '0, 4'd15, 1'b1);
        do_lookup("wrap0", kb, '0, 4'd0, 1'b1);

        // Backpressure: hold a result for four cycles while a second key waits.
        drive_ctrl(1'b0);
        key_valid = 1'b1; key_in = k5; key_mask_in = '0; phv_in = rand_wide(); ready_in = 1'b1;
        apply_stimulus();
        key_in = k3; phv_in = rand_wide(); ready_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus();
            check_output("bp_ready_out", ready_out, 1'b0);
            check_output("bp_hold_addr", match_addr, 4'd5);
        end
        ready_in = 1'b1;
        apply_stimulus();
        check_output("bp_second_addr", match_addr, 4'd3);
        key_valid = 1'b0;
        apply_stimulus();

        push_packet(8'h02, 4'd1, 16'hf2f1, 8'd5, 2, rand_key(), rand_key(), '0);
        push_packet(8'h0a, 4'd0, 16'hf2f1, 8'd3, 1, rand_key(), '0, '0);
        push_packet(8'h02, 4'd0, 16'hf2f1, 8'd9, 0, '0, '0, '0);
        flush_ctrl();
        do_lookup("pass_keep5", k5, '0, 4'd5, 1'b1);
        do_lookup("pass_keep9", k9, '0, 4'd9, 1'b1);

        // Reset in the middle of a packet: the leftover beats come in as headers.
        push_packet(8'h02, 4'd0, 16'hf2f1, 8'd7, 3, rand_key(), rand_key(), rand_key());
        for (int i = 0; i < 2; i++) begin
            drive_ctrl(1'b0);
            apply_stimulus();
        end
        rst = 1'b1;
        #1;
        check_output("midrst_phv_valid", phv_valid, 1'b0);
        check_output("midrst_c_m_tvalid", c_m_axis_tvalid, 1'b0);
        check_output("midrst_ready_out", ready_out, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        flush_ctrl();
        do_lookup("midrst_nohit", k5, '0, 4'd0, 1'b0);

        for (int cyc = 0; cyc < 800; cyc++) begin
            if (ctrl_q.size() == 0 && $urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0, 1: push_packet({5'd0, 3'd2}, 4'd0, 16'hf2f1, 8'($urandom), $urandom_range(0, 3),
                                      rand_key(), rand_key(), rand_key());
                    2:    push_packet(8'h02, 4'($urandom_range(1, 15)), 16'hf2f1, 8'($urandom), 2,
                                      rand_key(), rand_key(), '0);
                    default: push_packet(8'($urandom_range(0, 255)) | 8'h08, 4'd0,
                                         ($urandom_range(0, 1) != 0) ? 16'hf2f1 : 16'h1234,
                                         8'($urandom), 1, rand_key(), '0, '0);
                endcase
            end
            drive_ctrl(1'b1);
            kr = rand_key();
            mr = rand_key() & rand_key() & rand_key();
            if ($urandom_range(0, 1) != 0) kr = cam_m[$urandom_range(0, 15)] ^ (rand_key() & mr);
            if ($urandom_range(0, 15) == 0) mr = '1;
            key_valid   = ($urandom_range(0, 9) < 7);
            key_in      = kr;
            key_mask_in = mr;
            phv_in      = rand_wide();
            ready_in    = ($urandom_range(0, 3) != 0);
            apply_stimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
